// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared system bus.
// One master at a time holds a registered one-hot grant for as long as it keeps
// its request up. While it owns the bus, a watchdog counts consecutive transfer
// cycles that have not been acknowledged by fc_bus. If the count runs out, the
// grant is revoked and the offending master is logged in a sticky error flag.
module bus_arbiter #(
  parameter int MASTERS        = 4,
  parameter int IDX_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MASTERS-1:0]   req,
  output logic [MASTERS-1:0]   grant,
  input  logic                 rd_bus,
  input  logic                 wr_bus,
  input  logic                 fc_bus,
  output logic                 timeout,
  output logic                 err,
  output logic [IDX_WIDTH-1:0] err_master,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // The watchdog value at which one more unacknowledged cycle means abort.
  // Because the abort fires at this value, the counter never needs to wrap.
  localparam logic [CNT_WIDTH-1:0] LP_WD_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] LP_LAST_RST = IDX_WIDTH'(MASTERS - 1);
  localparam logic [MASTERS-1:0]   LP_ONE      = MASTERS'(1);

  // Round-robin pick: the first requester strictly after 'last', wrapping.
  // The previous owner is checked last, so it has the lowest priority.
  function automatic logic [IDX_WIDTH-1:0] f_rr_pick(
    input logic [MASTERS-1:0]   reqs,
    input logic [IDX_WIDTH-1:0] last
  );
    logic [IDX_WIDTH-1:0] pick;
    logic [IDX_WIDTH-1:0] cand_idx;
    logic                 found;
    int                   cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MASTERS; k++) begin
      cand     = (int'(last) + k) % MASTERS;
      cand_idx = IDX_WIDTH'(cand);
      if (!found && reqs[cand_idx]) begin
        pick  = cand_idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [MASTERS-1:0]   r_grant;
  logic [MASTERS-1:0]   w_grant_nxt;
  logic [IDX_WIDTH-1:0] r_last_idx;
  logic [IDX_WIDTH-1:0] w_last_nxt;
  logic [CNT_WIDTH-1:0] r_wdog;
  logic [CNT_WIDTH-1:0] w_wdog_nxt;
  logic                 r_timeout;
  logic                 w_timeout_nxt;
  logic                 r_err;
  logic                 w_err_nxt;
  logic [IDX_WIDTH-1:0] r_err_master;
  logic [IDX_WIDTH-1:0] w_err_master_nxt;

  logic                 w_xfer;
  logic                 w_fc_done;
  logic                 w_any_req;
  logic                 w_owner_req;
  logic [IDX_WIDTH-1:0] w_pick;

  // A transfer is exactly one strobe high; both or neither is an idle bus.
  assign w_xfer      = rd_bus ^ wr_bus;
  // Only a solid 1 completes; an undriven or unknown line is not completion.
  assign w_fc_done   = (fc_bus == 1'b1);
  assign w_any_req   = |req;
  // r_last_idx doubles as the owner index in OWNED and the aborted master in ABORT.
  assign w_owner_req = req[r_last_idx];
  assign w_pick      = f_rr_pick(req, r_last_idx);

  // Next-state, grant, watchdog and error bookkeeping.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_nxt       = r_last_idx;
    w_wdog_nxt       = r_wdog;
    w_timeout_nxt    = 1'b0;
    w_err_nxt        = err_clr ? 1'b0 : r_err;
    w_err_master_nxt = r_err_master;

    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        w_wdog_nxt  = '0;
        if (w_any_req) begin
          w_grant_nxt = LP_ONE << w_pick;
          w_last_nxt  = w_pick;
          w_state_nxt = ST_OWNED;
        end
      end

      ST_OWNED: begin
        if (!w_owner_req) begin
          // Release takes precedence over a watchdog expiring on the same edge.
          w_grant_nxt = '0;
          w_wdog_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_xfer) begin
          if (w_fc_done) begin
            w_wdog_nxt = '0;
          end else if (r_wdog == LP_WD_LAST) begin
            // Abort outranks a simultaneous err_clr: err ends up set.
            w_grant_nxt      = '0;
            w_timeout_nxt    = 1'b1;
            w_err_nxt        = 1'b1;
            w_err_master_nxt = r_last_idx;
            w_wdog_nxt       = '0;
            w_state_nxt      = ST_ABORT;
          end else begin
            w_wdog_nxt = r_wdog + CNT_WIDTH'(1);
          end
        end else begin
          w_wdog_nxt = '0;
        end
      end

      ST_ABORT: begin
        // Hold off until the faulting master lets go, so it cannot be re-granted
        // in a loop; it is then last in round-robin order.
        w_grant_nxt = '0;
        w_wdog_nxt  = '0;
        if (!w_owner_req) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_grant_nxt = '0;
        w_wdog_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the grant without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_idx   <= LP_LAST_RST;
      r_wdog       <= '0;
      r_timeout    <= 1'b0;
      r_err        <= 1'b0;
      r_err_master <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_idx   <= w_last_nxt;
      r_wdog       <= w_wdog_nxt;
      r_timeout    <= w_timeout_nxt;
      r_err        <= w_err_nxt;
      r_err_master <= w_err_master_nxt;
    end
  end

  assign grant      = r_grant;
  assign timeout    = r_timeout;
  assign err        = r_err;
  assign err_master = r_err_master;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter (4 masters, 4-cycle watchdog).
// The driver applies inputs on the falling edge, advances a behavioural model by
// one rising edge and queues the outputs it predicts; a monitor pops one entry
// just after every rising edge and compares it with the DUT.
module tb_bus_arbiter;

  localparam int M = 4;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       rd_bus;
  logic       wr_bus;
  logic       fc_bus;
  logic       timeout;
  logic       err;
  logic [1:0] err_master;
  logic       err_clr;

  bus_arbiter #(
    .MASTERS(M), .IDX_WIDTH(2), .TIMEOUT_CYCLES(T), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .rd_bus(rd_bus), .wr_bus(wr_bus), .fc_bus(fc_bus),
    .timeout(timeout), .err(err), .err_master(err_master), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic       tmo;
    logic       err;
    logic [1:0] em;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model: who owns the bus (-1 none), which aborted master is being waited
  // out (-1 none), the previous winner, and the run of unacknowledged transfers.
  int m_owner, m_hold, m_last, m_unack, m_em;
  bit m_err, m_tmo;

  function automatic void model_reset();
    m_owner = -1; m_hold = -1; m_last = M - 1; m_unack = 0;
    m_err = 1'b0; m_tmo = 1'b0; m_em = 0;
  endfunction

  function automatic bit req_of(input int i);
    return ((req >> i) & 4'b0001) != 4'b0000;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  function automatic void model_edge();
    bit nerr;
    bit xfer;
    bit done;
    int c;
    if (!rst) begin
      model_reset();
      return;
    end
    m_tmo = 1'b0;
    nerr  = err_clr ? 1'b0 : m_err;
    xfer  = (int'(rd_bus) + int'(wr_bus)) == 1;
    done  = (fc_bus === 1'b1);
    if (m_owner >= 0) begin
      if (!req_of(m_owner)) begin
        m_owner = -1;
      end else if (xfer && !done) begin
        m_unack++;
        if (m_unack == T) begin
          m_tmo = 1'b1; nerr = 1'b1; m_em = m_owner;
          m_hold = m_owner; m_owner = -1; m_unack = 0;
        end
      end else begin
        m_unack = 0;
      end
    end else if (m_hold >= 0) begin
      if (!req_of(m_hold)) m_hold = -1;
    end else if (req != 4'b0000) begin
      for (int k = 1; k <= M; k++) begin
        c = (m_last + k) % M;
        if (m_owner < 0 && req_of(c)) m_owner = c;
      end
      m_last  = m_owner;
      m_unack = 0;
    end
    m_err = nerr;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.tmo   = m_tmo;
    e.err   = m_err;
    e.em    = 2'(m_em);
    return e;
  endfunction

  // One clock of stimulus: predict, queue, move on to the next falling edge.
  task automatic step();
    model_edge();
    sb_q.push_back(model_out());
    @(negedge clk);
  endtask

  // Monitor: compare one predicted cycle just after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if (grant !== e.grant || timeout !== e.tmo || err !== e.err ||
          err_master !== e.em || !$onehot0(grant)) begin
        n_err++;
        $display("FAIL cycle@%0t: grant=%b timeout=%b err=%b err_master=%0d, required grant=%b timeout=%b err=%b err_master=%0d",
                 $time, grant, timeout, err, err_master, e.grant, e.tmo, e.err, e.em);
      end
    end
  end

  // Masters that keep their request for 'len' granted cycles, then drop it for one cycle.
  task automatic run_tenures(input logic [3:0] mask, input int len, input int cycles);
    int held[4];
    int off[4];
    for (int i = 0; i < 4; i++) begin held[i] = 0; off[i] = 0; end
    for (int n = 0; n < cycles; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!mask[i]) req[i] = 1'b0;
        else if (off[i] > 0) begin req[i] = 1'b0; off[i]--; end
        else req[i] = 1'b1;
      end
      step();
      for (int i = 0; i < 4; i++) begin
        if (m_owner == i) begin
          held[i]++;
          if (held[i] == len) begin held[i] = 0; off[i] = 1; end
        end
      end
    end
  endtask

  task automatic sync_reset_pulse();
    rst = 1'b0; req = '0; rd_bus = 0; wr_bus = 0; fc_bus = 0; err_clr = 0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; req = '0; rd_bus = 0; wr_bus = 0; fc_bus = 0; err_clr = 0;
    model_reset();
    @(negedge clk);
    step(); step();
    rst = 1'b1;

    // Idle after reset: nothing granted, no pulses.
    repeat (5) step();

    // Two requesters alternate with 3-cycle tenures.
    run_tenures(4'b0101, 3, 24);
    req = '0; step(); step();

    // All four requesting, 4-cycle tenures: strict rotation.
    run_tenures(4'b1111, 4, 30);
    req = '0; step(); step();

    // Master 2 stalls a read until the watchdog aborts; master 3 waits behind it.
    sync_reset_pulse();
    req = 4'b0100; step();
    req = 4'b1100; rd_bus = 1'b1; fc_bus = 1'bz;
    repeat (7) step();
    req = 4'b1000; rd_bus = 1'b0; fc_bus = 1'b0;
    repeat (3) step();

    // Master 3 writes with a completion every third cycle: never aborts.
    wr_bus = 1'b1;
    for (int k = 0; k < 9; k++) begin
      fc_bus = (k % 3 == 2);
      step();
    end
    wr_bus = 1'b0; fc_bus = 1'b0;
    err_clr = 1'b1; step();
    err_clr = 1'b0; step(); step();

    // Asynchronous reset between clock edges drops the grant immediately.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if (grant !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset: grant=%b, required 0000", grant);
    end
    model_reset();
    @(negedge clk);
    req = 4'b0000; step();
    rst = 1'b1; req = 4'b0010;
    repeat (3) step();
    req = 4'b0000; step(); step();

    // Randomized traffic, including stalls, abort/clear collisions and releases.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      rd_bus  = 1'($urandom_range(0, 1));
      wr_bus  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       fc_bus = 1'b1;
        1:       fc_bus = 1'bz;
        default: fc_bus = 1'b0;
      endcase
      err_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predicted cycles never checked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares the single system bus (addr_bus/data_bus/wr_bus/rd_bus/fc_bus) between up to MASTERS bus masters, such as the CPU and DMA-style engines.
- Issues one-hot grants and monitors the granted master's transfers with a watchdog.
- A transfer is any cycle with exactly one of rd_bus/wr_bus high. If a transfer sees no fc_bus completion within TIMEOUT_CYCLES, the arbiter revokes the grant and logs the faulting master.
- Address/data muxing of master outputs onto the bus is outside this block. It consumes grant.

Parameters:
- MASTERS, 4, number of requesters (2..8).
- IDX_WIDTH, 2, width of master index (ceil(log2(MASTERS))).
- TIMEOUT_CYCLES, 255, max cycles a transfer may wait for fc_bus==1 (1..2^CNT_WIDTH-1).
- CNT_WIDTH, 8, watchdog counter width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset; asynchronous and active-low (0 = reset).
- req  input  MASTERS  per-master bus request, level; held high for the whole tenure.
- grant  output  MASTERS  one-hot (or zero) bus grant.
- rd_bus  input  1  bus read strobe as driven by granted master.
- wr_bus  input  1  bus write strobe as driven by granted master.
- fc_bus  input  1  bus function-complete; only 1'b1 counts as complete (0/z/x = not complete).
- timeout  output  1  one-cycle pulse when a watchdog abort occurs.
- err  output  1  sticky error flag, set on abort.
- err_master  output  IDX_WIDTH  index of master that caused the last abort.
- err_clr  input  1  synchronous clear of err (err_master retained).

Behaviour:
- Reset (rst=0, asynchronous): grant=0, timeout=0, err=0, err_master=0, watchdog=0, last_idx=MASTERS-1, state=IDLE. Reset mid-tenure drops grant immediately, without waiting for a clock edge.
- States: IDLE, OWNED, ABORT.
- IDLE:
  - grant=0.
  - If any req bit is set, the winner is the first set bit searching upward from last_idx+1, wrapping modulo MASTERS.
  - Next edge: grant[winner]=1, last_idx=winner, watchdog=0, state=OWNED.
  - Latency req->grant is 1 cycle.
- OWNED, per edge in priority order:
  - (1) req[owner]==0: grant=0, state=IDLE. Re-arbitration happens on the following edge, so there are at least 2 cycles between tenures. Release wins over a simultaneous timeout.
  - (2) Transfer active and fc_bus==1: watchdog=0.
  - (3) Transfer active and fc_bus!=1: if watchdog==TIMEOUT_CYCLES-1, abort. Otherwise watchdog+1.
  - (4) No transfer (idle or rd_bus&wr_bus both high): watchdog=0.
  - Other requesters never preempt an owner.
- Abort:
  - grant=0, timeout=1 for exactly one cycle, err=1, err_master=owner index, watchdog=0, state=ABORT.
  - An abort occurs exactly TIMEOUT_CYCLES consecutive unacknowledged transfer cycles after the transfer starts.
- ABORT:
  - grant=0.
  - Stay until req[aborted master]==0, then go to IDLE. This prevents an immediate re-grant loop.
  - last_idx is already the aborted master, so it has lowest priority next.
- err_clr:
  - err_clr=1 clears err on the next edge.
  - If an abort and err_clr occur in the same cycle, the abort wins (err stays 1).
- Output timing: grant is a registered output and is never more than one-hot. timeout is registered.
- Watchdog width: the counter saturates logic-free because the abort check occurs before overflow; TIMEOUT_CYCLES < 2^CNT_WIDTH is required.

Test Plan:
- Reset release, req=0000 for 5 cycles -> grant=0000, err=0, timeout never pulses.
- req=0101 held, each owner drops req after 3 cycles and re-raises 1 cycle later -> grants alternate 0001,0100,0001,0100. Each grant arrives 1 cycle after IDLE. There are 2 dead cycles between tenures.
- req=1111 constant with 4-cycle tenures -> grant sequence 0001,0010,0100,1000,0001. No master is granted twice before all others.
- Owner 2 with TIMEOUT_CYCLES=4 asserts rd_bus, fc_bus=z -> after 4 transfer cycles: grant=0000, 1-cycle timeout pulse, err=1, err_master=2. No re-grant while req[2] stays high. Master 3 (if requesting) is granted after req[2] drops.
- Owner does 3 writes with fc_bus=1 on every 3rd cycle, TIMEOUT_CYCLES=4 -> no abort (watchdog resets on each completion). Then err_clr pulse with err=1 -> err=0 next cycle, err_master unchanged.
- rst driven low mid-tenure between clock edges -> grant=0000 asynchronously. After release with req=0010 -> grant=0010 one cycle later.
